reservation_station: RTL and testbench

- Consumer end of the common data bus (CDB). Holds up to DEPTH dispatched instructions and snoops every CDB broadcast (tag + data).
- Captures a waiting operand when its source tag matches the broadcast tag.
- Issues operand-complete instructions to one functional unit (adder or multiplier) over a valid/ready handshake.
- One instance sits in front of each FU. Its issue tag is the tag that FU later broadcasts on the CDB.

---
 rtl/tomasulo_pkg.sv | 39 +++
 rtl/rs_entry.sv | 76 +++++++
 rtl/reservation_station.sv | 164 ++++++++++++++++
 tb/tb_reservation_station.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types and widths for the Tomasulo reservation-station slice.
// Tag 0 is reserved: a NULL_TAG source means the operand value is already present.
package tomasulo_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;  // enough for the 1..7 entry range

  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef struct packed {
    logic              busy;
    op_t               op;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } rs_entry_t;

  // Issue-side selection state: OPEN re-arbitrates each cycle, HELD pins a stalled offer.
  typedef enum logic {
    ISS_OPEN = 1'b0,
    ISS_HELD = 1'b1
  } iss_state_t;

  function automatic logic cdb_hit(input logic             cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] q);
    return cdb_valid && (cdb_tag != NULL_TAG) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: loads on dispatch, snoops the CDB for missing
// operands, and is released when its instruction is accepted by the FU.
module rs_entry
  import tomasulo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [1:0]        load_op_i,
  input  logic [TAG_W-1:0]  load_qj_i,
  input  logic [DATA_W-1:0] load_vj_i,
  input  logic [TAG_W-1:0]  load_qk_i,
  input  logic [DATA_W-1:0] load_vk_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [1:0]        op_o,
  output logic [DATA_W-1:0] vj_o,
  output logic [DATA_W-1:0] vk_o
);

  rs_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (load_i) begin
      // A broadcast landing in the dispatch cycle is folded in here so it is never lost.
      entry_d.busy = 1'b1;
      entry_d.op   = op_t'(load_op_i);
      if (cdb_hit(cdb_valid_i, cdb_tag_i, load_qj_i)) begin
        entry_d.qj = NULL_TAG;
        entry_d.vj = cdb_data_i;
      end else begin
        entry_d.qj = load_qj_i;
        entry_d.vj = load_vj_i;
      end
      if (cdb_hit(cdb_valid_i, cdb_tag_i, load_qk_i)) begin
        entry_d.qk = NULL_TAG;
        entry_d.vk = cdb_data_i;
      end else begin
        entry_d.qk = load_qk_i;
        entry_d.vk = load_vk_i;
      end
    end else if (entry_q.busy) begin
      if (clear_i) begin
        entry_d.busy = 1'b0;
      end
      if (cdb_hit(cdb_valid_i, cdb_tag_i, entry_q.qj)) begin
        entry_d.qj = NULL_TAG;
        entry_d.vj = cdb_data_i;
      end
      if (cdb_hit(cdb_valid_i, cdb_tag_i, entry_q.qk)) begin
        entry_d.qk = NULL_TAG;
        entry_d.vk = cdb_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign busy_o  = entry_q.busy;
  assign ready_o = entry_q.busy && (entry_q.qj == NULL_TAG) && (entry_q.qk == NULL_TAG);
  assign op_o    = entry_q.op;
  assign vj_o    = entry_q.vj;
  assign vk_o    = entry_q.vk;

endmodule

// File: rtl/reservation_station.sv
// Reservation station in front of one functional unit: allocates the lowest free
// entry, and offers the lowest operand-complete entry over valid/ready.
//
// Issue handshake: iss_valid/iss_op/iss_a/iss_b/iss_tag describe one offer; a
// transfer happens on a rising edge where iss_valid && iss_ready. Once iss_valid
// is raised it is held with an unchanged payload until that transfer occurs.
module reservation_station #(
  parameter int DEPTH    = 3,
  parameter int BASE_TAG = 1,
  parameter int TAG_W    = tomasulo_pkg::TAG_W,
  parameter int DATA_W   = tomasulo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [1:0]        disp_op,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic [DATA_W-1:0] disp_vk,
  output logic              disp_ready,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [1:0]        iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_tag,
  output logic              dbg_iss_state
);

  import tomasulo_pkg::*;

  if (DEPTH < 1 || DEPTH > 7 || BASE_TAG < 1 ||
      (BASE_TAG + DEPTH - 1) >= (1 << TAG_W) ||
      TAG_W != tomasulo_pkg::TAG_W || DATA_W != tomasulo_pkg::DATA_W) begin : g_bad_params
    $error("reservation_station: tag range BASE_TAG..BASE_TAG+DEPTH-1 must be non-zero and fit TAG_W");
  end

  logic [DEPTH-1:0]  ent_busy;
  logic [DEPTH-1:0]  ent_ready;
  logic [DEPTH-1:0]  ent_load;
  logic [DEPTH-1:0]  ent_clear;
  logic [1:0]        ent_op [DEPTH];
  logic [DATA_W-1:0] ent_vj [DEPTH];
  logic [DATA_W-1:0] ent_vk [DEPTH];

  iss_state_t        state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;

  logic              any_free;
  logic [IDX_W-1:0]  free_idx;
  logic              any_rdy;
  logic [IDX_W-1:0]  rdy_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              accept;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rs_entry u_entry (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ent_load[g]),
      .clear_i    (ent_clear[g]),
      .load_op_i  (disp_op),
      .load_qj_i  (disp_qj),
      .load_vj_i  (disp_vj),
      .load_qk_i  (disp_qk),
      .load_vk_i  (disp_vk),
      .cdb_valid_i(cdb_valid),
      .cdb_tag_i  (cdb_tag),
      .cdb_data_i (cdb_data),
      .busy_o     (ent_busy[g]),
      .ready_o    (ent_ready[g]),
      .op_o       (ent_op[g]),
      .vj_o       (ent_vj[g]),
      .vk_o       (ent_vk[g])
    );
  end

  // Priority encoders: scanning downwards lets the lowest index win.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    any_rdy  = 1'b0;
    rdy_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_ready[i]) begin
        any_rdy = 1'b1;
        rdy_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    if (state_q == ISS_HELD) begin
      iss_valid = 1'b1;
      sel_idx   = sel_q;
    end else begin
      iss_valid = any_rdy;
      sel_idx   = rdy_idx;
    end
  end

  assign accept = iss_valid && iss_ready;

  always_comb begin
    iss_op  = '0;
    iss_a   = '0;
    iss_b   = '0;
    iss_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_load[i]  = disp_valid && any_free && (free_idx == IDX_W'(i));
      ent_clear[i] = accept && (sel_idx == IDX_W'(i));
      if (iss_valid && (sel_idx == IDX_W'(i))) begin
        iss_op  = ent_op[i];
        iss_a   = ent_vj[i];
        iss_b   = ent_vk[i];
        iss_tag = TAG_W'(BASE_TAG) + TAG_W'(sel_idx);
      end
    end
  end

  assign disp_ready = any_free;
  assign disp_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ISS_OPEN: begin
        if (iss_valid && !iss_ready) begin
          state_d = ISS_HELD;
          sel_d   = sel_idx;
        end
      end
      ISS_HELD: begin
        if (iss_ready) begin
          state_d = ISS_OPEN;
        end
      end
      default: state_d = ISS_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ISS_OPEN;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign dbg_iss_state = state_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: scenario tasks check offers inline,
// and a negedge scoreboard pops the expected queue on every accepted issue.
module tb_reservation_station;

  logic        clk;
  logic        reset;
  logic        disp_valid;
  logic [1:0]  disp_op;
  logic [3:0]  disp_qj;
  logic [31:0] disp_vj;
  logic [3:0]  disp_qk;
  logic [31:0] disp_vk;
  logic        disp_ready;
  logic [3:0]  disp_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_op;
  logic [31:0] iss_a;
  logic [31:0] iss_b;
  logic [3:0]  iss_tag;
  logic        dbg_iss_state;

  int checks;
  int failures;
  logic [69:0] exp_q[$];
  logic [70:0] offer;
  logic [69:0] exp_item;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3;

  reservation_station #(.DEPTH(3), .BASE_TAG(1), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_qj(disp_qj), .disp_vj(disp_vj), .disp_qk(disp_qk), .disp_vk(disp_vk),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag),
    .dbg_iss_state(dbg_iss_state)
  );

  assign offer = {iss_valid, iss_op, iss_a, iss_b, iss_tag};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted issue must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && iss_valid && iss_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_issue got op=%0d a=%h b=%h tag=%0d exp=none", iss_op, iss_a, iss_b, iss_tag);
      end else begin
        exp_item = exp_q.pop_front();
        if ({iss_op, iss_a, iss_b, iss_tag} !== exp_item) begin
          failures++;
          $display("FAIL sb_issue got=%h exp=%h", {iss_op, iss_a, iss_b, iss_tag}, exp_item);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [1:0] op, input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] qk, input logic [31:0] vk);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_qj    = qj;
    disp_vj    = vj;
    disp_qk    = qk;
    disp_vk    = vk;
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0;
    disp_op    = '0;
    disp_qj    = '0;
    disp_vj    = '0;
    disp_qk    = '0;
    disp_vk    = '0;
  endtask

  task automatic drive_cdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = v;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    idle_disp();
    drive_cdb(1'b0, 4'd0, 32'd0);
    iss_ready = 1'b0;
    #12;
    checks++;
    if ({disp_ready, disp_tag, offer} !== {1'b1, 4'd1, 71'd0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%0b tag=%0d offer=%h exp rdy=1 tag=1 offer=0", disp_ready, disp_tag, offer);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_add();
    drive_disp(ADD, 4'd0, 32'd5, 4'd0, 32'd7);
    iss_ready = 1'b1;
    exp_q.push_back({ADD, 32'd5, 32'd7, 4'd1});
    #1;
    checks++;
    if ({disp_ready, disp_tag, iss_valid} !== {1'b1, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL add_dispatch got rdy=%0b tag=%0d iv=%0b exp rdy=1 tag=1 iv=0", disp_ready, disp_tag, iss_valid);
    end
    step();
    idle_disp();
    #1;
    checks++;
    if (offer !== {1'b1, ADD, 32'd5, 32'd7, 4'd1}) begin
      failures++;
      $display("FAIL add_offer got=%h exp iv=1 a=5 b=7 tag=1", offer);
    end
    step();
    checks++;
    if ({iss_valid, disp_tag} !== {1'b0, 4'd1}) begin
      failures++;
      $display("FAIL add_freed got iv=%0b tag=%0d exp iv=0 tag=1", iss_valid, disp_tag);
    end
    iss_ready = 1'b0;
  endtask

  task automatic test_cdb_capture();
    drive_disp(MUL, 4'd4, 32'hFFFF_FFFF, 4'd0, 32'd3);
    iss_ready = 1'b1;
    exp_q.push_back({MUL, 32'h10, 32'd3, 4'd1});
    step();
    idle_disp();
    #1;
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL cap_wait got iv=%0b exp iv=0", iss_valid);
    end
    step();
    drive_cdb(1'b1, 4'd4, 32'h10);
    #1;
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL cap_no_bypass got iv=%0b exp iv=0", iss_valid);
    end
    step();
    drive_cdb(1'b0, 4'd0, 32'd0);
    #1;
    checks++;
    if (offer !== {1'b1, MUL, 32'h10, 32'd3, 4'd1}) begin
      failures++;
      $display("FAIL cap_offer got=%h exp iv=1 op=2 a=10 b=3 tag=1", offer);
    end
    step();
    iss_ready = 1'b0;
  endtask

  task automatic test_dual_capture();
    drive_disp(SUB, 4'd5, 32'd0, 4'd5, 32'd0);
    iss_ready = 1'b1;
    exp_q.push_back({SUB, 32'h22, 32'h22, 4'd1});
    step();
    idle_disp();
    drive_cdb(1'b1, 4'd5, 32'h22);
    step();
    drive_cdb(1'b0, 4'd0, 32'd0);
    #1;
    checks++;
    if (offer !== {1'b1, SUB, 32'h22, 32'h22, 4'd1}) begin
      failures++;
      $display("FAIL dual_offer got=%h exp iv=1 op=1 a=22 b=22 tag=1", offer);
    end
    step();
    iss_ready = 1'b0;
  endtask

  task automatic test_null_tag();
    drive_disp(ADD, 4'd0, 32'd1, 4'd0, 32'd2);
    exp_q.push_back({ADD, 32'd1, 32'd2, 4'd1});
    step();
    idle_disp();
    drive_cdb(1'b1, 4'd0, 32'hDEAD_BEEF);
    step();
    drive_cdb(1'b0, 4'd0, 32'd0);
    #1;
    checks++;
    if (offer !== {1'b1, ADD, 32'd1, 32'd2, 4'd1}) begin
      failures++;
      $display("FAIL null_tag_ignored got=%h exp a=1 b=2 tag=1", offer);
    end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
  endtask

  task automatic test_collision();
    drive_disp(ADD, 4'd6, 32'd0, 4'd0, 32'd2);
    drive_cdb(1'b1, 4'd6, 32'd9);
    iss_ready = 1'b1;
    exp_q.push_back({ADD, 32'd9, 32'd2, 4'd1});
    step();
    idle_disp();
    drive_cdb(1'b0, 4'd0, 32'd0);
    #1;
    checks++;
    if (offer !== {1'b1, ADD, 32'd9, 32'd2, 4'd1}) begin
      failures++;
      $display("FAIL collision_offer got=%h exp iv=1 a=9 b=2 tag=1", offer);
    end
    step();
    iss_ready = 1'b0;
  endtask

  task automatic test_full();
    exp_q.push_back({ADD, 32'd1, 32'd1, 4'd1});
    exp_q.push_back({SUB, 32'd2, 32'd2, 4'd2});
    exp_q.push_back({MUL, 32'd3, 32'd3, 4'd3});
    for (int i = 1; i <= 3; i++) begin
      drive_disp(2'(i - 1), 4'd0, 32'(i), 4'd0, 32'(i));
      #1;
      checks++;
      if ({disp_ready, disp_tag} !== {1'b1, 4'(i)}) begin
        failures++;
        $display("FAIL full_alloc%0d got rdy=%0b tag=%0d exp rdy=1 tag=%0d", i, disp_ready, disp_tag, i);
      end
      step();
    end
    drive_disp(DIV, 4'd0, 32'hAA, 4'd0, 32'hBB);
    #1;
    checks++;
    if (disp_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_not_ready got rdy=%0b exp rdy=0", disp_ready);
    end
    step();
    idle_disp();
    iss_ready = 1'b1;
    #1;
    checks++;
    if ({disp_ready, iss_valid, iss_tag} !== {1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL full_ignored got rdy=%0b iv=%0b tag=%0d exp rdy=0 iv=1 tag=1", disp_ready, iss_valid, iss_tag);
    end
    step();
    iss_ready = 1'b0;
    #1;
    checks++;
    if ({disp_ready, disp_tag, iss_tag} !== {1'b1, 4'd1, 4'd2}) begin
      failures++;
      $display("FAIL full_freed got rdy=%0b dtag=%0d itag=%0d exp rdy=1 dtag=1 itag=2", disp_ready, disp_tag, iss_tag);
    end
    iss_ready = 1'b1;
    step();
    step();
    iss_ready = 1'b0;
    #1;
    checks++;
    if ({iss_valid, disp_ready, disp_tag} !== {1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL full_drained got iv=%0b rdy=%0b tag=%0d exp iv=0 rdy=1 tag=1", iss_valid, disp_ready, disp_tag);
    end
  endtask

  task automatic test_lock();
    exp_q.push_back({DIV, 32'h33, 32'h44, 4'd3});
    exp_q.push_back({ADD, 32'h55, 32'h11, 4'd1});
    exp_q.push_back({SUB, 32'h66, 32'h22, 4'd2});
    drive_disp(ADD, 4'd8, 32'd0, 4'd0, 32'h11);
    step();
    drive_disp(SUB, 4'd9, 32'd0, 4'd0, 32'h22);
    step();
    drive_disp(DIV, 4'd0, 32'h33, 4'd0, 32'h44);
    step();
    idle_disp();
    drive_cdb(1'b1, 4'd8, 32'h55);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({offer, dbg_iss_state} !== {1'b1, DIV, 32'h33, 32'h44, 4'd3, (c != 0)}) begin
        failures++;
        $display("FAIL lock_stall%0d got=%h held=%0b exp tag=3 a=33 b=44", c, offer, dbg_iss_state);
      end
      if (c == 2) iss_ready = 1'b1;
      step();
      drive_cdb(1'b0, 4'd0, 32'd0);
    end
    #1;
    checks++;
    if (offer !== {1'b1, ADD, 32'h55, 32'h11, 4'd1}) begin
      failures++;
      $display("FAIL lock_next got=%h exp tag=1 a=55 b=11", offer);
    end
    step();
    drive_cdb(1'b1, 4'd9, 32'h66);
    #1;
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL lock_waiting got iv=%0b exp iv=0", iss_valid);
    end
    step();
    drive_cdb(1'b0, 4'd0, 32'd0);
    #1;
    checks++;
    if (offer !== {1'b1, SUB, 32'h66, 32'h22, 4'd2}) begin
      failures++;
      $display("FAIL lock_last got=%h exp tag=2 a=66 b=22", offer);
    end
    step();
    iss_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    exp_q.push_back({ADD, 32'd1, 32'd2, 4'd1});
    exp_q.push_back({SUB, 32'h77, 32'd4, 4'd2});
    exp_q.push_back({DIV, 32'hA, 32'hB, 4'd3});
    drive_disp(ADD, 4'd0, 32'd1, 4'd0, 32'd2);
    step();
    drive_disp(SUB, 4'd7, 32'd0, 4'd0, 32'd4);
    step();
    drive_disp(DIV, 4'd0, 32'hA, 4'd0, 32'hB);
    drive_cdb(1'b1, 4'd7, 32'h77);
    iss_ready = 1'b1;
    #1;
    checks++;
    if ({disp_tag, iss_valid, iss_tag} !== {4'd3, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL conc_same_cycle got dtag=%0d iv=%0b itag=%0d exp dtag=3 iv=1 itag=1", disp_tag, iss_valid, iss_tag);
    end
    step();
    idle_disp();
    drive_cdb(1'b0, 4'd0, 32'd0);
    #1;
    checks++;
    if ({offer, disp_tag} !== {1'b1, SUB, 32'h77, 32'd4, 4'd2, 4'd1}) begin
      failures++;
      $display("FAIL conc_after got=%h dtag=%0d exp tag=2 a=77 b=4 dtag=1", offer, disp_tag);
    end
    step();
    step();
    #1;
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL conc_drained got iv=%0b exp iv=0", iss_valid);
    end
    iss_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_disp(ADD, 4'd0, 32'h5, 4'd0, 32'h6);
    step();
    drive_disp(MUL, 4'd0, 32'h7, 4'd0, 32'h8);
    #1;
    checks++;
    if (iss_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got iv=%0b exp iv=1", iss_valid);
    end
    step();
    idle_disp();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({disp_ready, disp_tag, offer, dbg_iss_state} !== {1'b1, 4'd1, 71'd0, 1'b0}) begin
      failures++;
      $display("FAIL areset_immediate got rdy=%0b tag=%0d offer=%h exp rdy=1 tag=1 offer=0", disp_ready, disp_tag, offer);
    end
    step();
    step();
    reset = 1'b0;
    iss_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({iss_valid, disp_tag} !== {1'b0, 4'd1}) begin
        failures++;
        $display("FAIL areset_post%0d got iv=%0b tag=%0d exp iv=0 tag=1", c, iss_valid, disp_tag);
      end
    end
    iss_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_add();
    test_cdb_capture();
    test_dual_capture();
    test_null_tag();
    test_collision();
    test_full();
    test_lock();
    test_concurrent();
    test_async_reset();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
